// File: rtl/uart_baud_gen.sv
// uart_baud_gen: runtime-programmable UART baud generator.
// One divider produces an oversampled rx_tick, a 1x tx_tick coincident with
// the rx_tick that wraps the oversample phase, and the phase index itself.
// Optional feature macro: UART_FRAC_DIV_EN adds a fractional accumulator so
// that the mean period is D + F/2^FRAC_W clk cycles.
module uart_baud_gen #(
  parameter int SYS_CLK      = 50000000,
  parameter int BAUD_DEFAULT = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_en,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  output logic                          rx_tick,
  output logic                          tx_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] rx_phase,
  output logic                          cfg_err
);

  localparam int PH_W    = $clog2(OVERSAMPLE);
  localparam int DIV_RST = (SYS_CLK / (BAUD_DEFAULT * OVERSAMPLE));

  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
  localparam logic [PH_W-1:0]  PH_MAX    = PH_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W:0]   CNT_ONE   = (DIV_W+1)'(1);

  // Counter is one bit wider than the divisor so a D+1 period cannot overflow.
  logic [DIV_W:0]   count;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] shadow_int;
  logic             pending;
  logic [DIV_W:0]   period_last;
  logic             load_ok;
  logic             load_bad;
  logic             wrap;
  logic             apply_edge;
  logic             apply_now;
  logic [DIV_W-1:0] next_int;

  // A load is legal only when the divisor is at least 2.
  assign load_ok  = div_load && (div_int >= DIV_W'(2));
  assign load_bad = div_load && (div_int <  DIV_W'(2));

  // Divisor updates only take effect at a period boundary or while idle.
  assign wrap       = baud_en && (count == period_last);
  assign apply_edge = wrap || !baud_en;
  assign apply_now  = apply_edge && (pending || load_ok);

  // A load on the apply edge itself wins over an older shadow value.
  assign next_int = load_ok ? div_int : shadow_int;

`ifdef UART_FRAC_DIV_EN
  logic [FRAC_W-1:0] frac_act;
  logic [FRAC_W-1:0] shadow_frac;
  logic [FRAC_W-1:0] frac_acc;
  logic              extra;
  logic [FRAC_W-1:0] next_frac;
  logic [FRAC_W:0]   frac_sum;

  assign next_frac   = load_ok ? div_frac : shadow_frac;
  assign frac_sum    = {1'b0, frac_acc} + {1'b0, frac_act};
  assign period_last = {1'b0, div_act} + {{DIV_W{1'b0}}, extra} - CNT_ONE;

  // Fractional shadow/active registers follow the integer divisor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frac_act    <= '0;
      shadow_frac <= '0;
    end else begin
      if (load_ok)   shadow_frac <= div_frac;
      if (apply_now) frac_act    <= next_frac;
    end
  end

  // Accumulate fraction per period; a carry stretches the next period by 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frac_acc <= '0;
      extra    <= 1'b0;
    end else if (!baud_en || apply_now) begin
      frac_acc <= '0;
      extra    <= 1'b0;
    end else if (wrap) begin
      frac_acc <= frac_sum[FRAC_W-1:0];
      extra    <= frac_sum[FRAC_W];
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign period_last = {1'b0, div_act} - CNT_ONE;
`endif

  // Shadow register and pending flag for deferred divisor loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_int <= '0;
      pending    <= 1'b0;
    end else if (load_ok) begin
      shadow_int <= div_int;
      pending    <= !apply_edge;
    end else if (apply_edge) begin
      pending    <= 1'b0;
    end
  end

  // Active divisor: reset default, replaced only at an apply edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           div_act <= DIV_RST_V;
    else if (apply_now) div_act <= next_int;
  end

  // Period counter: held at zero when disabled, restarts on wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         count <= '0;
    else if (!baud_en) count <= '0;
    else if (wrap)    count <= '0;
    else              count <= count + CNT_ONE;
  end

  // Oversample phase and both ticks; phase wraps by compare for any OVERSAMPLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_tick  <= 1'b0;
      tx_tick  <= 1'b0;
      rx_phase <= '0;
    end else if (!baud_en) begin
      rx_tick  <= 1'b0;
      tx_tick  <= 1'b0;
      rx_phase <= '0;
    end else begin
      rx_tick <= wrap;
      tx_tick <= wrap && (rx_phase == PH_MAX);
      if (wrap) rx_phase <= (rx_phase == PH_MAX) ? '0 : rx_phase + PH_W'(1);
    end
  end

  // Rejected loads raise a single-cycle error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cfg_err <= 1'b0;
    else      cfg_err <= load_bad;
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed checks of tick spacing, phase, reload and reset.
module tb_uart_baud_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              baud_en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              rx_tick;
  logic              tx_tick;
  logic [3:0]        rx_phase;
  logic              cfg_err;

  int checks = 0;
  int errors = 0;
  int exp_phase = 0;
  int stray_tx = 0;
  int tx_seen = 0;

  uart_baud_gen dut (
    .clk(clk), .rst(rst), .baud_en(baud_en), .div_int(div_int),
    .div_frac(div_frac), .div_load(div_load), .rx_tick(rx_tick),
    .tx_tick(tx_tick), .rx_phase(rx_phase), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until rx_tick is seen, bounded by max.
  task automatic wait_rx(input int max, output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if (tx_tick && !rx_tick) stray_tx++;
      if (rx_tick) break;
      if (n >= max) begin
        chk("rx_timeout", n, -1);
        break;
      end
    end
  endtask

  // Wait for the next tick, check spacing, phase and tx coincidence.
  task automatic tick_chk(input string tag, input int exp_n);
    int n;
    wait_rx(exp_n + 50, n);
    chk(tag, n, exp_n);
    exp_phase = (exp_phase + 1) % 16;
    chk({tag, "_phase"}, int'(rx_phase), exp_phase);
    chk({tag, "_tx"}, int'(tx_tick), (exp_phase == 0) ? 1 : 0);
    if (tx_tick) tx_seen++;
  endtask

  initial begin
    rst = 1'b0; baud_en = 1'b0; div_int = '0; div_frac = '0; div_load = 1'b0;
    step(); step();
    chk("rst_rx", int'(rx_tick), 0);
    chk("rst_tx", int'(tx_tick), 0);
    chk("rst_phase", int'(rx_phase), 0);
    chk("rst_err", int'(cfg_err), 0);

    // Defaults: D=325, full bit of 16 ticks, tx on the wrap to phase 0.
    rst = 1'b1; baud_en = 1'b1;
    for (int i = 0; i < 16; i++) tick_chk("dflt", 325);

    // Illegal divisor is rejected with a 1-cycle error, spacing unchanged.
    div_int = 16'd1; div_load = 1'b1;
    step();
    chk("err_hi", int'(cfg_err), 1);
    div_load = 1'b0;
    step();
    chk("err_lo", int'(cfg_err), 0);
    tick_chk("err_p0", 323);
    tick_chk("err_p1", 325);

    // Disable at count=50: silent while low, phase cleared, full period after.
    repeat (50) step();
    baud_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rx_tick || tx_tick) chk("dis_quiet", 1, 0);
    end
    chk("dis_phase", int'(rx_phase), 0);
    exp_phase = 0;
    baud_en = 1'b1;
    tick_chk("reen", 325);

    // Load 4 at count=100: current period finishes at 325, then 4.
    repeat (100) step();
    div_int = 16'd4; div_load = 1'b1;
    step();
    div_load = 1'b0;
    tick_chk("ld_tail", 224);
    for (int i = 0; i < 3; i++) tick_chk("ld_4", 4);

    // Two loads before apply: only the latest (6) takes effect.
    div_int = 16'd9; div_load = 1'b1;
    step();
    div_int = 16'd6;
    step();
    div_load = 1'b0;
    tick_chk("ow_tail", 2);
    tick_chk("ow_6a", 6);
    tick_chk("ow_6b", 6);

    // Load while disabled applies on the next edge.
    baud_en = 1'b0;
    div_int = 16'd10; div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    exp_phase = 0;
    baud_en = 1'b1;
    tick_chk("idle_10a", 10);
    tick_chk("idle_10b", 10);

    // Async reset right on a tick: outputs drop immediately, D back to 325.
    rst = 1'b0;
    #1;
    chk("arst_rx", int'(rx_tick), 0);
    chk("arst_phase", int'(rx_phase), 0);
    chk("arst_tx", int'(tx_tick), 0);
    step(); step();
    rst = 1'b1;
    exp_phase = 0;
    tick_chk("arst_325", 325);

`ifdef UART_FRAC_DIV_EN
    // D=4, F=8/16: periods 4,4,5,4,5,... ; one tx per 16 ticks.
    begin
      int acc = 0;
      int ext = 0;
      baud_en = 1'b0;
      div_int = 16'd4; div_frac = 4'd8; div_load = 1'b1;
      step();
      div_load = 1'b0;
      step();
      exp_phase = 0;
      tx_seen = 0;
      baud_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
        tick_chk("frac", 4 + ext);
        acc = acc + 8;
        ext = (acc >= 16) ? 1 : 0;
        acc = acc % 16;
      end
      chk("frac_tx", tx_seen, 1);
    end
`endif

    chk("stray_tx", stray_tx, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
